// File: rtl/esram_array_if.sv
// Bus bundle for the esram_array: per-channel write/read ports, shutdown requests and status.
// Handshake: wr_en/rd_en take effect only in a cycle where ready is high, otherwise they are dropped and counted; each accepted read yields exactly one rd_valid pulse.
interface esram_array_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 72,
  parameter int ADDR_W = 11
);
  logic [NUM_CH-1:0]        wr_en;
  logic [NUM_CH*ADDR_W-1:0] wr_addr;
  logic [NUM_CH*DATA_W-1:0] wr_data;
  logic [NUM_CH-1:0]        rd_en;
  logic [NUM_CH*ADDR_W-1:0] rd_addr;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0]        rd_valid;
  logic [NUM_CH-1:0]        sd_n;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH*16-1:0]     drop_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, sd_n,
    input  rd_data, rd_valid, ready, drop_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, sd_n,
    output rd_data, rd_valid, ready, drop_cnt
  );
endinterface

// File: rtl/esram_array.sv
// Multi-channel simple dual-port RAM array with per-channel power sequencing,
// optional zero-clear after reset, configurable read latency and dropped-access counters.
module esram_array #(
  parameter int NUM_CH         = 8,
  parameter int DATA_W         = 72,
  parameter int ADDR_W         = 11,
  parameter int READ_LATENCY   = 2,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int WAKE_CYCLES    = 16
) (
  input  logic              clk,
  input  logic              rst,
  esram_array_if.slave      bus,
  output logic [NUM_CH*2-1:0] state_dbg
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int WC_W  = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t              state;
    state_t              state_nx;
    logic                ready_q;
    logic [ADDR_W-1:0]   init_cnt;
    logic [WC_W-1:0]     wake_cnt;
    logic [15:0]         drops;
    logic [1:0]          rej;
    logic [16:0]         drop_sum;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok;
    logic                rd_ok;
    logic [ADDR_W-1:0]   wa;
    logic [ADDR_W-1:0]   ra;
    logic [DATA_W-1:0]   wd;
    logic [DATA_W-1:0]   rd_word;
    logic [READ_LATENCY-1:0] pv;
    logic [DATA_W-1:0]   pd [READ_LATENCY];

    assign wa    = bus.wr_addr[c*ADDR_W +: ADDR_W];
    assign ra    = bus.rd_addr[c*ADDR_W +: ADDR_W];
    assign wd    = bus.wr_data[c*DATA_W +: DATA_W];
    assign wr_ok = bus.wr_en[c] & ready_q;
    assign rd_ok = bus.rd_en[c] & ready_q;

    always_comb begin
      state_nx = state;
      unique case (state)
        ST_INIT:  if (init_cnt == {ADDR_W{1'b1}}) state_nx = ST_READY;
        ST_READY: if (!bus.sd_n[c]) state_nx = ST_SLEEP;
        ST_SLEEP: if (bus.sd_n[c]) state_nx = ST_WAKE;
        ST_WAKE: begin
          if (!bus.sd_n[c])                              state_nx = ST_SLEEP;
          else if (wake_cnt == WC_W'(WAKE_CYCLES - 1))   state_nx = ST_READY;
        end
        default:  state_nx = ST_READY;
      endcase
    end

    // ready mirrors the state register, so it is derived from the next state here.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
        ready_q  <= 1'b0;
        init_cnt <= '0;
        wake_cnt <= '0;
      end else begin
        state    <= state_nx;
        ready_q  <= (state_nx == ST_READY);
        init_cnt <= (state == ST_INIT) ? init_cnt + 1'b1 : '0;
        wake_cnt <= (state == ST_WAKE && state_nx == ST_WAKE) ? wake_cnt + 1'b1 : '0;
      end
    end

    assign rej      = {1'b0, bus.wr_en[c] & ~ready_q} + {1'b0, bus.rd_en[c] & ~ready_q};
    assign drop_sum = {1'b0, drops} + {15'd0, rej};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) drops <= '0;
      else     drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // The zero-fill owns the write port while INIT runs; no access is accepted then.
    always_ff @(posedge clk) begin
      if (state == ST_INIT) mem[init_cnt] <= '0;
      else if (wr_ok)       mem[wa] <= wd;
    end

    assign rd_word = (RDW_NEW != 0 && wr_ok && wa == ra) ? wd : mem[ra];

    // Data stages only load behind a valid so the output holds between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv <= '0;
        for (int k = 0; k < READ_LATENCY; k++) pd[k] <= '0;
      end else begin
        pv[0] <= rd_ok;
        if (rd_ok) pd[0] <= rd_word;
        for (int k = 1; k < READ_LATENCY; k++) begin
          pv[k] <= pv[k-1];
          if (pv[k-1]) pd[k] <= pd[k-1];
        end
      end
    end

    assign bus.rd_valid[c]                  = pv[READ_LATENCY-1];
    assign bus.rd_data[c*DATA_W +: DATA_W]  = pd[READ_LATENCY-1];
    assign bus.ready[c]                     = ready_q;
    assign bus.drop_cnt[c*16 +: 16]         = drops;
    assign state_dbg[c*2 +: 2]              = state;
  end
endmodule
